// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between two writeback
//   sources. Source A (single-cycle datapath) has priority and is written
//   with zero latency. Source B (long-latency unit) results are held in a
//   small in-order queue and drain whenever A leaves the port idle. An age
//   counter on the queue head lets B override A after MAX_WAIT cycles so B
//   cannot starve. Queued B results that a newer A write has overtaken are
//   squashed and drain without writing. Register 31 is never written.
//
// Optional feature:
//   REGFILE_ARB_FWD_EN - when defined, chk_data1/chk_data2 carry the data of
//   the youngest live queued entry targeting chk_reg1/chk_reg2, so decode can
//   forward instead of stalling. When undefined they are tied to zero.
//
// Parameters:
//   DEPTH    - B queue entries (power of two, >= 2)
//   MAX_WAIT - cycles the queue head may wait before it overrides A (>= 1)
//
// Ports:
//   clk                   clock, all state updates on posedge
//   reset                 synchronous, active-high; flushes the queue
//   a_valid/a_ready       A handshake
//   a_reg/a_data          A destination register and result
//   b_valid/b_ready       B handshake into the queue
//   b_reg/b_data          B destination register and result
//   wr_en/wr_reg/wr_data  register file write port
//   chk_reg1/chk_reg2     source registers of the instruction in decode
//   chk_hit1/chk_hit2     a live queued B write targets chk_regN
//   chk_data1/chk_data2   forwarded value (zero unless forwarding enabled)
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [63:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [63:0] b_data,
    output logic        wr_en,
    output logic [4:0]  wr_reg,
    output logic [63:0] wr_data,
    input  logic [4:0]  chk_reg1,
    input  logic [4:0]  chk_reg2,
    output logic        chk_hit1,
    output logic        chk_hit2,
    output logic [63:0] chk_data1,
    output logic [63:0] chk_data2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] AGE_MAX  = AW'(MAX_WAIT);
    localparam logic [4:0]    NULL_REG = 5'd31;

    // Queue storage: live flags are reset, payload is not.
    logic [DEPTH-1:0] q_live;
    logic [4:0]       q_reg  [DEPTH];
    logic [63:0]      q_data [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] age;

    logic head_valid;
    logic head_live;
    logic pop;
    logic push;
    logic a_accept;
    logic squash;
    logic push_live;

    assign head_valid = (count != '0);
    assign head_live  = head_valid && q_live[rd_ptr];

    // Write-port selection. Priority order: drop a dead head (A still served),
    // let an over-age live head override A, serve A, otherwise drain the head.
    // Everything is forced quiet while reset is asserted.
    always_comb begin
        pop     = 1'b0;
        a_ready = 1'b1;
        wr_en   = 1'b0;
        wr_reg  = '0;
        wr_data = '0;
        if (reset) begin
            pop = 1'b0;
        end else if (head_valid && !head_live) begin
            pop = 1'b1;
            if (a_valid) begin
                wr_en   = (a_reg != NULL_REG);
                wr_reg  = a_reg;
                wr_data = a_data;
            end
        end else if (head_live && (age == AGE_MAX)) begin
            wr_en   = 1'b1;
            wr_reg  = q_reg[rd_ptr];
            wr_data = q_data[rd_ptr];
            pop     = 1'b1;
            a_ready = 1'b0;
        end else if (a_valid) begin
            wr_en   = (a_reg != NULL_REG);
            wr_reg  = a_reg;
            wr_data = a_data;
        end else if (head_live) begin
            wr_en   = 1'b1;
            wr_reg  = q_reg[rd_ptr];
            wr_data = q_data[rd_ptr];
            pop     = 1'b1;
        end
    end

    // b_ready looks only at the registered count, never at a same-cycle pop,
    // so it has no combinational path from A.
    assign b_ready  = reset || (count < DEPTH_C);
    assign push     = b_valid && b_ready && !reset;
    assign a_accept = a_valid && a_ready && !reset;
    assign squash   = a_accept && (a_reg != NULL_REG);

    // An entry arriving in the same cycle as a younger-in-program-order A
    // write to the same register is already stale, so it enters dead.
    assign push_live = (b_reg != NULL_REG) && !(squash && (b_reg == a_reg));

    // Queue control state: live flags, pointers, occupancy and head age.
    // Popped slots have their live flag cleared so that "live" also implies
    // "occupied", which keeps the hazard search free of an occupancy mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_live <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            age    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && (q_reg[i] == a_reg)) begin
                    q_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            if (push) begin
                q_live[wr_ptr] <= push_live;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop || !head_valid) begin
                age <= '0;
            end else if (head_live && (age != AGE_MAX)) begin
                age <= age + AW'(1);
            end
        end
    end

    // Queue payload; written only on enqueue, meaningless unless live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= b_reg;
            q_data[wr_ptr] <= b_data;
        end
    end

    // Hazard search over current queue contents, oldest to youngest, so the
    // last match seen is the youngest live entry for that register.
    logic          hit1;
    logic          hit2;
    logic [63:0]   fwd1;
    logic [63:0]   fwd2;
    logic [PW-1:0] idx;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (q_live[idx] && (q_reg[idx] == chk_reg1)) begin
                hit1 = 1'b1;
                fwd1 = q_data[idx];
            end
            if (q_live[idx] && (q_reg[idx] == chk_reg2)) begin
                hit2 = 1'b1;
                fwd2 = q_data[idx];
            end
        end
    end

    assign chk_hit1 = !reset && (chk_reg1 != NULL_REG) && hit1;
    assign chk_hit2 = !reset && (chk_reg2 != NULL_REG) && hit2;

`ifdef REGFILE_ARB_FWD_EN
    assign chk_data1 = chk_hit1 ? fwd1 : 64'd0;
    assign chk_data2 = chk_hit2 ? fwd2 : 64'd0;
`else
    // Without forwarding the searched data is intentionally discarded.
    logic unused_fwd;
    assign unused_fwd = ^{fwd1, fwd2};
    assign chk_data1  = 64'd0;
    assign chk_data2  = 64'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed-vector bench for regfile_write_arbiter with DEPTH = 2 and
// MAX_WAIT = 4. Inputs change just after each negedge and outputs are
// checked 1 time unit later, well away from the active posedge. A small
// register file model captures every write the DUT performs.
// ----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [4:0]  a_reg = '0;
    logic [63:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_reg = '0;
    logic [63:0] b_data = '0;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [63:0] wr_data;
    logic [4:0]  chk_reg1 = 5'd31;
    logic [4:0]  chk_reg2 = 5'd31;
    logic        chk_hit1;
    logic        chk_hit2;
    logic [63:0] chk_data1;
    logic [63:0] chk_data2;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] model [32];

    regfile_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .chk_reg1  (chk_reg1),
        .chk_reg2  (chk_reg2),
        .chk_hit1  (chk_hit1),
        .chk_hit2  (chk_hit2),
        .chk_data1 (chk_data1),
        .chk_data2 (chk_data2)
    );

    always #5 clk = ~clk;

    // Register file model: records whatever the DUT writes.
    always @(posedge clk) begin
        if (!reset && wr_en) begin
            model[wr_reg] <= wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ar,
                                 input logic [63:0] ad, input logic bv,
                                 input logic [4:0] br, input logic [63:0] bd,
                                 input logic [4:0] c1, input logic [4:0] c2);
        @(negedge clk);
        reset    = rst;
        a_valid  = av;
        a_reg    = ar;
        a_data   = ad;
        b_valid  = bv;
        b_reg    = br;
        b_data   = bd;
        chk_reg1 = c1;
        chk_reg2 = c2;
        #1;
    endtask

    logic [63:0] fwd_expect;

    initial begin
`ifdef REGFILE_ARB_FWD_EN
        fwd_expect = 64'h6;
`else
        fwd_expect = 64'h0;
`endif
        // Reset, with A and a hazard query active to prove the outputs are gated.
        applyStimulus(1, 1, 5'd3, 64'h99, 1, 5'd4, 64'h1, 5'd4, 5'd3);
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_a_ready", 64'(a_ready), 64'd1);
        checkOutput("rst_b_ready", 64'(b_ready), 64'd1);
        checkOutput("rst_chk_hit1", 64'(chk_hit1), 64'd0);
        checkOutput("rst_chk_data1", chk_data1, 64'd0);
        applyStimulus(1, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd4, 5'd31);
        checkOutput("post_rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("post_rst_b_ready", 64'(b_ready), 64'd1);
        checkOutput("post_rst_chk_hit1", 64'(chk_hit1), 64'd0);

        // A write, zero latency.
        applyStimulus(0, 1, 5'd3, 64'h11, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("a_wr_en", 64'(wr_en), 64'd1);
        checkOutput("a_wr_reg", 64'(wr_reg), 64'd3);
        checkOutput("a_wr_data", wr_data, 64'h11);
        checkOutput("a_a_ready", 64'(a_ready), 64'd1);

        // B enqueue with A idle: written next cycle, hazard visible for one cycle.
        applyStimulus(0, 0, 5'd0, 64'h0, 1, 5'd5, 64'hAA, 5'd5, 5'd31);
        checkOutput("b_enq_wr_en", 64'(wr_en), 64'd0);
        checkOutput("b_enq_hit", 64'(chk_hit1), 64'd0);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd5, 5'd31);
        checkOutput("b_wr_en", 64'(wr_en), 64'd1);
        checkOutput("b_wr_reg", 64'(wr_reg), 64'd5);
        checkOutput("b_wr_data", wr_data, 64'hAA);
        checkOutput("b_hit", 64'(chk_hit1), 64'd1);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd5, 5'd31);
        checkOutput("b_after_wr_en", 64'(wr_en), 64'd0);
        checkOutput("b_after_hit", 64'(chk_hit1), 64'd0);

        // Anti-starvation: R7 queued under continuous A, overrides on cycle 5.
        applyStimulus(0, 1, 5'd1, 64'h100, 1, 5'd7, 64'h77, 5'd31, 5'd31);
        checkOutput("age_c0_wr_reg", 64'(wr_reg), 64'd1);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 1, 5'(10 + i), 64'(i), 0, 5'd0, 64'h0, 5'd31, 5'd31);
            checkOutput($sformatf("age_c%0d_a_ready", i), 64'(a_ready), (i == 5) ? 64'd0 : 64'd1);
            checkOutput($sformatf("age_c%0d_wr_reg", i), 64'(wr_reg), (i == 5) ? 64'd7 : 64'(10 + i));
            checkOutput($sformatf("age_c%0d_wr_en", i), 64'(wr_en), 64'd1);
        end

        // Squash: B R9=1 queued, A overwrites R9=2, stale entry drains silently.
        applyStimulus(0, 0, 5'd0, 64'h0, 1, 5'd9, 64'h1, 5'd9, 5'd31);
        applyStimulus(0, 1, 5'd9, 64'h2, 0, 5'd0, 64'h0, 5'd9, 5'd31);
        checkOutput("sq_a_wr_reg", 64'(wr_reg), 64'd9);
        checkOutput("sq_a_wr_data", wr_data, 64'h2);
        checkOutput("sq_hit_before", 64'(chk_hit1), 64'd1);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd9, 5'd31);
        checkOutput("sq_drain_wr_en", 64'(wr_en), 64'd0);
        checkOutput("sq_hit_after", 64'(chk_hit1), 64'd0);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("sq_idle_wr_en", 64'(wr_en), 64'd0);
        checkOutput("sq_final_r9", model[9], 64'h2);

        // Fill the queue under continuous A; includes a dead R31 entry.
        applyStimulus(0, 1, 5'd12, 64'h12, 1, 5'd13, 64'h13, 5'd31, 5'd31);
        checkOutput("fill_c0_b_ready", 64'(b_ready), 64'd1);
        applyStimulus(0, 1, 5'd14, 64'h14, 1, 5'd31, 64'h31, 5'd31, 5'd31);
        checkOutput("fill_c1_b_ready", 64'(b_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(0, 1, 5'(21 + j), 64'(j), 1, 5'd16, 64'h16, 5'd31, 5'd31);
            checkOutput($sformatf("fill_c%0d_b_ready", j + 2), 64'(b_ready), 64'd0);
        end
        checkOutput("fill_c5_wr_reg", 64'(wr_reg), 64'd13);
        checkOutput("fill_c5_wr_data", wr_data, 64'h13);
        checkOutput("fill_c5_a_ready", 64'(a_ready), 64'd0);
        applyStimulus(0, 1, 5'd25, 64'h25, 1, 5'd16, 64'h16, 5'd31, 5'd31);
        checkOutput("fill_c6_b_ready", 64'(b_ready), 64'd1);
        checkOutput("fill_c6_wr_en", 64'(wr_en), 64'd1);
        checkOutput("fill_c6_wr_reg", 64'(wr_reg), 64'd25);
        applyStimulus(0, 1, 5'd31, 64'hDEAD, 0, 5'd0, 64'h0, 5'd16, 5'd31);
        checkOutput("a_r31_wr_en", 64'(wr_en), 64'd0);
        checkOutput("a_r31_a_ready", 64'(a_ready), 64'd1);
        checkOutput("fill_c7_hit", 64'(chk_hit1), 64'd1);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd16, 5'd31);
        checkOutput("fill_c8_wr_reg", 64'(wr_reg), 64'd16);
        checkOutput("fill_c8_wr_data", wr_data, 64'h16);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("fill_c9_wr_en", 64'(wr_en), 64'd0);

        // Reset flushes two live queued entries.
        applyStimulus(0, 1, 5'd1, 64'h1, 1, 5'd20, 64'h20, 5'd31, 5'd31);
        applyStimulus(0, 1, 5'd2, 64'h2, 1, 5'd21, 64'h21, 5'd31, 5'd31);
        applyStimulus(0, 1, 5'd3, 64'h3, 0, 5'd0, 64'h0, 5'd20, 5'd21);
        checkOutput("flush_pre_hit1", 64'(chk_hit1), 64'd1);
        checkOutput("flush_pre_hit2", 64'(chk_hit2), 64'd1);
        checkOutput("flush_pre_b_ready", 64'(b_ready), 64'd0);
        applyStimulus(1, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd20, 5'd21);
        checkOutput("flush_rst_hit1", 64'(chk_hit1), 64'd0);
        checkOutput("flush_rst_wr_en", 64'(wr_en), 64'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd20, 5'd21);
            checkOutput($sformatf("flush_idle%0d_wr_en", k), 64'(wr_en), 64'd0);
        end
        checkOutput("flush_b_ready", 64'(b_ready), 64'd1);
        checkOutput("flush_hit1", 64'(chk_hit1), 64'd0);
        checkOutput("flush_hit2", 64'(chk_hit2), 64'd0);

        // Two queued R4 entries: youngest value forwarded when enabled.
        applyStimulus(0, 1, 5'd1, 64'h1, 1, 5'd4, 64'h5, 5'd31, 5'd31);
        applyStimulus(0, 1, 5'd2, 64'h2, 1, 5'd4, 64'h6, 5'd31, 5'd31);
        applyStimulus(0, 1, 5'd3, 64'h3, 0, 5'd0, 64'h0, 5'd4, 5'd4);
        checkOutput("fwd_hit1", 64'(chk_hit1), 64'd1);
        checkOutput("fwd_data1", chk_data1, fwd_expect);
        checkOutput("fwd_data2", chk_data2, fwd_expect);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("fwd_drain0_wr_data", wr_data, 64'h5);
        applyStimulus(0, 0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 5'd31, 5'd31);
        checkOutput("fwd_drain1_wr_data", wr_data, 64'h6);
        checkOutput("fwd_drain1_wr_reg", 64'(wr_reg), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
